// File: rtl/mem_stage.sv
// Pipeline MEM stage: byte/half/word loads and stores on a word-organised,
// little-endian data memory, load extension, MEM/WB pipeline register,
// sticky misalignment flag and a registered debug read port.
module mem_stage #(
    parameter int NB_DATA   = 32,
    parameter int MEM_DEPTH = 256,
    parameter int NB_ADDR   = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_mem_data,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_misaligned
);

    localparam int NB_BYTES = NB_DATA / 8;

    typedef enum logic [1:0] {
        WIDTH_BYTE     = 2'b00,
        WIDTH_HALF     = 2'b01,
        WIDTH_WORD     = 2'b10,
        WIDTH_WORD_ALT = 2'b11
    } width_e;

    logic [NB_DATA-1:0]  mem [MEM_DEPTH];

    width_e              width;
    logic [NB_ADDR-1:0]  word_idx;
    logic [1:0]          byte_lane;
    logic                half_lane;
    logic [NB_DATA-1:0]  rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [NB_DATA-1:0]  ld_ext;
    logic                aligned;
    logic                access_bad;
    logic                load_bad;
    logic                wr_en;
    logic [NB_BYTES-1:0] wr_be;
    logic [NB_DATA-1:0]  wr_data;

    // Address bits above the word index wrap the memory and are ignored.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign width     = width_e'(i_width);
    assign word_idx  = i_result[NB_ADDR+1:2];
    assign byte_lane = i_result[1:0];
    assign half_lane = i_result[1];

    // Read, lane-select and extend; decide alignment and store lane enables.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        ld_ext  = '0;
        aligned = 1'b1;
        wr_be   = '0;
        wr_data = i_data4Mem;
        rd_word = mem[word_idx];
        rd_byte = rd_word[{byte_lane, 3'b000} +: 8];
        rd_half = rd_word[{half_lane, 4'b0000} +: 16];
        case (width)
            WIDTH_BYTE: begin
                ld_ext  = {{(NB_DATA-8){i_sign_flag & rd_byte[7]}}, rd_byte};
                aligned = 1'b1;
                wr_be   = NB_BYTES'(1) << byte_lane;
                wr_data = {NB_BYTES{i_data4Mem[7:0]}};
            end
            WIDTH_HALF: begin
                ld_ext  = {{(NB_DATA-16){i_sign_flag & rd_half[15]}}, rd_half};
                aligned = ~i_result[0];
                wr_be   = half_lane ? 4'b1100 : 4'b0011;
                wr_data = {(NB_BYTES/2){i_data4Mem[15:0]}};
            end
            default: begin
                ld_ext  = rd_word;
                aligned = (i_result[1:0] == 2'b00);
                wr_be   = '1;
                wr_data = i_data4Mem;
            end
        endcase
    end

    assign access_bad = (i_memWrite | i_mem2reg) & ~aligned;
    assign load_bad   = i_mem2reg & ~aligned;
    assign wr_en      = i_memWrite & aligned & ~i_halt & i_reset;

    // Byte-lane store into the data memory.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; only the write enable is gated by i_reset.
        if (wr_en) begin
            for (int b = 0; b < NB_BYTES; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // MEM/WB pipeline register and sticky misalignment flag, frozen on halt.
    always_ff @(posedge clk or negedge i_reset) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (!i_reset) begin
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_write_reg  <= '0;
            o_mem_data   <= '0;
            o_result     <= '0;
            o_misaligned <= 1'b0;
        end else if (!i_halt) begin
            o_mem2reg    <= i_mem2reg;
            o_regWrite   <= i_regWrite & ~load_bad;
            o_write_reg  <= i_write_reg;
            o_mem_data   <= load_bad ? '0 : ld_ext;
            o_result     <= i_result;
            o_misaligned <= o_misaligned | access_bad;
        end
    end

    // Debug read port, keeps running while halted; sees pre-write data.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) o_dbg_data <= '0;
        else          o_dbg_data <= mem[i_dbg_addr];
    end

    // Writeback value forwarded to EX.
    assign o_wb_data = o_mem2reg ? o_mem_data : o_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random traffic
// compared against a byte-addressed memory model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        i_reset, i_halt, i_mem2reg, i_memWrite, i_regWrite, i_sign_flag;
    logic [1:0]  i_width;
    logic [4:0]  i_write_reg;
    logic [31:0] i_result, i_data4Mem;
    logic [7:0]  i_dbg_addr;
    logic        o_mem2reg, o_regWrite, o_misaligned;
    logic [4:0]  o_write_reg;
    logic [31:0] o_mem_data, o_result, o_wb_data, o_dbg_data;

    mem_stage dut (
        .clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_mem2reg(i_mem2reg),
        .i_memWrite(i_memWrite), .i_regWrite(i_regWrite), .i_width(i_width),
        .i_sign_flag(i_sign_flag), .i_write_reg(i_write_reg), .i_result(i_result),
        .i_data4Mem(i_data4Mem), .i_dbg_addr(i_dbg_addr), .o_mem2reg(o_mem2reg),
        .o_regWrite(o_regWrite), .o_write_reg(o_write_reg), .o_mem_data(o_mem_data),
        .o_result(o_result), .o_wb_data(o_wb_data), .o_dbg_data(o_dbg_data),
        .o_misaligned(o_misaligned)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit init_phase;

    // Reference model: 1 KiB byte-addressed memory plus expected outputs.
    logic [7:0]  bmem [1024];
    logic        e_mem2reg, e_regWrite, e_mis;
    logic [4:0]  e_write_reg;
    logic [31:0] e_mem_data, e_result, e_dbg;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(logic [31:0] a);
        int base = int'(a & 32'h3FC);
        return {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
    endfunction

    function automatic bit is_aligned(logic [31:0] a, logic [1:0] w);
        if (w == 2'd0) return 1'b1;
        if (w == 2'd1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] w, logic s);
        logic [31:0] v;
        v = word_at(a);
        if (w == 2'd0) begin
            v = (v >> (8 * (a % 4))) & 32'hFF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (w == 2'd1) begin
            v = (v >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic model_store(logic [31:0] a, logic [1:0] w, logic [31:0] d);
        int n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        int base = int'(a % 1024) / n * n;
        logic [31:0] t;
        for (int k = 0; k < n; k++) begin
            t = d >> (8 * k);
            bmem[base + k] = t[7:0];
        end
    endtask

    task automatic model_clear();
        e_mem2reg = 0; e_regWrite = 0; e_write_reg = 0; e_mem_data = 0;
        e_result = 0; e_mis = 0; e_dbg = 0;
    endtask

    task automatic check_outputs(string p);
        check({p, "_mem2reg"}, 32'(o_mem2reg), 32'(e_mem2reg));
        check({p, "_regWrite"}, 32'(o_regWrite), 32'(e_regWrite));
        check({p, "_write_reg"}, 32'(o_write_reg), 32'(e_write_reg));
        check({p, "_result"}, o_result, e_result);
        check({p, "_misaligned"}, 32'(o_misaligned), 32'(e_mis));
        if (!init_phase) begin
            check({p, "_mem_data"}, o_mem_data, e_mem_data);
            check({p, "_wb_data"}, o_wb_data, e_mem2reg ? e_mem_data : e_result);
            check({p, "_dbg_data"}, o_dbg_data, e_dbg);
        end
    endtask

    // One clock: predict from pre-edge model state, clock, then compare.
    task automatic step(string p);
        bit          al, bad_ld;
        logic [31:0] ld, dbg;
        al     = is_aligned(i_result, i_width);
        bad_ld = i_mem2reg && !al;
        ld     = model_load(i_result, i_width, i_sign_flag);
        dbg    = word_at(32'(i_dbg_addr) * 4);
        @(posedge clk);
        if (!i_halt) begin
            e_mem2reg   = i_mem2reg;
            e_regWrite  = i_regWrite && !bad_ld;
            e_write_reg = i_write_reg;
            e_mem_data  = bad_ld ? 32'h0 : ld;
            e_result    = i_result;
            if ((i_memWrite || i_mem2reg) && !al) e_mis = 1'b1;
            if (i_memWrite && al) model_store(i_result, i_width, i_data4Mem);
        end
        e_dbg = dbg;
        @(negedge clk);
        check_outputs(p);
    endtask

    task automatic idle_inputs();
        i_halt = 0; i_mem2reg = 0; i_memWrite = 0; i_regWrite = 0;
        i_width = 2'd2; i_sign_flag = 0; i_write_reg = 0;
        i_result = 0; i_data4Mem = 0;
    endtask

    task automatic store(logic [31:0] a, logic [1:0] w, logic [31:0] d, string p);
        idle_inputs();
        i_memWrite = 1; i_width = w; i_result = a; i_data4Mem = d;
        step(p);
    endtask

    task automatic load(logic [31:0] a, logic [1:0] w, logic s, string p);
        idle_inputs();
        i_mem2reg = 1; i_regWrite = 1; i_width = w; i_sign_flag = s;
        i_result = a; i_write_reg = 5'($urandom_range(1, 31));
        step(p);
    endtask

    // Store in flight when reset drops between edges: nothing is written.
    task automatic reset_mid_store(logic [31:0] a, logic [31:0] d, string p);
        idle_inputs();
        i_memWrite = 1; i_result = a; i_data4Mem = d;
        #2 i_reset = 0;
        #1;
        model_clear();
        check_outputs({p, "_async"});
        @(posedge clk);
        @(negedge clk);
        check_outputs({p, "_held"});
        i_memWrite = 0;
        i_reset = 1;
    endtask

    initial begin
        init_phase = 1;
        idle_inputs();
        i_dbg_addr = 0;
        i_reset = 0;
        #3;
        model_clear();
        check_outputs("reset");
        @(negedge clk);
        i_reset = 1;

        // Give every word a defined value before data outputs are compared.
        for (int i = 0; i < 256; i++) store(32'(i * 4), 2'd2, $urandom, "init");
        init_phase = 0;
        idle_inputs();
        step("first");

        // Word store / load.
        store(32'h10, 2'd2, 32'hDEADBEEF, "t1_sw");
        load(32'h10, 2'd2, 1, "t1_lw");
        check("t1_lw_val", o_mem_data, 32'hDEADBEEF);
        check("t1_wb_val", o_wb_data, 32'hDEADBEEF);

        // Byte lanes and extension.
        store(32'h11, 2'd0, 32'h7F, "t2_sb");
        load(32'h10, 2'd2, 0, "t2_lw");
        check("t2_word", o_mem_data, 32'hDEAD7FEF);
        load(32'h11, 2'd0, 1, "t2_lb");
        check("t2_lb_7f", o_mem_data, 32'h0000007F);
        store(32'h11, 2'd0, 32'h80, "t2_sb2");
        load(32'h11, 2'd0, 1, "t2_lb2");
        check("t2_lb_80", o_mem_data, 32'hFFFFFF80);
        load(32'h11, 2'd0, 0, "t2_lbu");
        check("t2_lbu_80", o_mem_data, 32'h00000080);

        // Half lanes and extension.
        store(32'h22, 2'd1, 32'h8001, "t3_sh");
        load(32'h22, 2'd1, 1, "t3_lh");
        check("t3_lh_val", o_mem_data, 32'hFFFF8001);
        load(32'h22, 2'd1, 0, "t3_lhu");
        check("t3_lhu_val", o_mem_data, 32'h00008001);
        load(32'h20, 2'd2, 0, "t3_lw");
        check("t3_upper", 32'(o_mem_data[31:16]), 32'h8001);

        // Misaligned load and store.
        load(32'h13, 2'd2, 1, "t4_lw");
        check("t4_data0", o_mem_data, 32'h0);
        check("t4_rw0", 32'(o_regWrite), 32'h0);
        check("t4_flag", 32'(o_misaligned), 32'h1);
        store(32'h15, 2'd1, 32'hAAAA, "t4_sh");
        load(32'h14, 2'd2, 0, "t4_chk");

        // Simultaneous store and load returns pre-write data.
        idle_inputs();
        i_memWrite = 1; i_mem2reg = 1; i_regWrite = 1; i_result = 32'h50; i_data4Mem = 32'h5A5A_1234;
        step("both");
        load(32'h50, 2'd2, 0, "both_after");
        check("both_new", o_mem_data, 32'h5A5A_1234);

        // Halt freezes MEM/WB and blocks stores; debug read keeps running.
        idle_inputs();
        i_halt = 1; i_memWrite = 1; i_result = 32'h30; i_data4Mem = 32'h1111_2222;
        i_mem2reg = 1; i_regWrite = 1; i_write_reg = 5'd9; i_dbg_addr = 8'd12;
        step("t5_halt");
        i_dbg_addr = 8'd0;
        load(32'h30, 2'd2, 0, "t5_after");

        // Async reset mid-store and address aliasing.
        store(32'h40, 2'd2, 32'h12345678, "t6_pre");
        reset_mid_store(32'h40, 32'hCAFEF00D, "t6_rst");
        load(32'h40, 2'd2, 0, "t6_ld");
        check("t6_nowrite", o_mem_data, 32'h12345678);
        store(32'h410, 2'd2, 32'h0BADF00D, "t6_alias_sw");
        load(32'h10, 2'd2, 0, "t6_alias_lw");
        check("t6_alias", o_mem_data, 32'h0BADF00D);

        // Random traffic with occasional halts and resets.
        for (int n = 0; n < 600; n++) begin
            if (n % 97 == 96) begin
                reset_mid_store(32'($urandom_range(0, 255)) * 4, $urandom, "rnd_rst");
            end else begin
                i_halt      = ($urandom % 8) == 0;
                i_mem2reg   = $urandom % 2;
                i_memWrite  = $urandom % 2;
                i_regWrite  = $urandom % 2;
                i_width     = 2'($urandom);
                i_sign_flag = $urandom % 2;
                i_write_reg = 5'($urandom);
                i_result    = 32'($urandom_range(0, 127));
                if ($urandom % 4 == 0) i_result = i_result | ($urandom & 32'hFFFF_FC00);
                i_data4Mem  = $urandom;
                i_dbg_addr  = 8'($urandom_range(0, 31));
                step("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
